// File: rtl/input_reader.sv
`default_nettype none
// ============================================================================
// Module      : input_reader
// Description : Fetches a delayed sample x[n-k] from a circular input memory.
//               A lag request is turned into one memory read. The read strobe
//               is held until the memory qualifies its data or a timeout
//               expires. Lags that reach past the recorded sample history
//               return zero without touching memory.
// Revision    : 1.0 - initial release
// ============================================================================
module input_reader #(
    parameter int MEM_DEPTH = 256,
    parameter int TIMEOUT   = 4
) (
    input  logic        sClk,
    input  logic        reset,
    input  logic        start,
    input  logic        new_Sample,
    input  logic [7:0]  wr_Ptr,
    input  logic        fetch_Req,
    input  logic [7:0]  fetch_Lag,
    output logic        rd_En,
    output logic [7:0]  rd_Addr,
    input  logic        data_Valid,
    input  logic [15:0] data_In,
    output logic [15:0] sample_Out,
    output logic        sample_Valid,
    output logic        busy,
    output logic        rd_Err
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [8:0]    c_CNT_MAX = 9'(MEM_DEPTH);
    localparam logic [TW-1:0] c_TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [8:0]      r_sample_cnt;
    logic [TW-1:0]   r_to_cnt;
    logic            w_accept;
    logic            w_skip;
    logic            w_waiting;
    logic            w_timeout;

    // A request is only taken from IDLE; start always wins.
    assign w_accept  = (r_state == S_IDLE) && fetch_Req && !start;
    // Comparison uses the count before any coincident new_Sample increment.
    assign w_skip    = ({1'b0, fetch_Lag} >= r_sample_cnt);
    assign w_waiting = (r_state == S_ISSUE) || (r_state == S_WAIT);
    // Timeout fires on the edge that would start another rd_En cycle past the limit.
    assign w_timeout = w_waiting && !data_Valid && (r_to_cnt == c_TO_LAST);

    assign busy         = w_waiting;
    assign sample_Valid = (r_state == S_DONE);

    // State register.
    always_ff @(posedge sClk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decision.
    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (fetch_Req) begin
                        w_next = w_skip ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (data_Valid) begin
                        w_next = S_DONE;
                    end else if (w_timeout) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
                S_DONE: begin
                    w_next = S_IDLE;
                end
                default: begin
                    w_next = S_IDLE;
                end
            endcase
        end
    end

    // Saturating count of samples written since the stream began.
    always_ff @(posedge sClk or posedge reset) begin
        if (reset) begin
            r_sample_cnt <= '0;
        end else if (start) begin
            r_sample_cnt <= '0;
        end else if (new_Sample && (r_sample_cnt < c_CNT_MAX)) begin
            r_sample_cnt <= r_sample_cnt + 9'd1;
        end
    end

    // Read strobe, address, timeout counter, returned sample and error flag.
    always_ff @(posedge sClk or posedge reset) begin
        if (reset) begin
            rd_En      <= 1'b0;
            rd_Addr    <= '0;
            sample_Out <= '0;
            rd_Err     <= 1'b0;
            r_to_cnt   <= '0;
        end else if (start) begin
            rd_En    <= 1'b0;
            rd_Err   <= 1'b0;
            r_to_cnt <= '0;
        end else if (w_accept) begin
            // Lag wraps modulo 256 regardless of history saturation.
            rd_Addr  <= wr_Ptr - fetch_Lag;
            r_to_cnt <= '0;
            if (w_skip) begin
                sample_Out <= '0;
            end else begin
                rd_En <= 1'b1;
            end
        end else if (w_waiting) begin
            if (data_Valid) begin
                sample_Out <= data_In;
                rd_En      <= 1'b0;
            end else if (w_timeout) begin
                rd_En  <= 1'b0;
                rd_Err <= 1'b1;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_input_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_reader
// Description : Randomized bench for input_reader. The bench owns the sample
//               memory and a count/sticky-error model of the reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_reader;

    localparam int TO = 4;

    logic        sClk = 1'b0;
    logic        reset;
    logic        start;
    logic        new_Sample;
    logic [7:0]  wr_Ptr;
    logic        fetch_Req;
    logic [7:0]  fetch_Lag;
    logic        rd_En;
    logic [7:0]  rd_Addr;
    logic        data_Valid;
    logic [15:0] data_In;
    logic [15:0] sample_Out;
    logic        sample_Valid;
    logic        busy;
    logic        rd_Err;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];
    logic [7:0]  wp;
    int          model_cnt;
    bit          model_err;

    input_reader #(.MEM_DEPTH(256), .TIMEOUT(TO)) dut (
        .sClk(sClk), .reset(reset), .start(start), .new_Sample(new_Sample),
        .wr_Ptr(wr_Ptr), .fetch_Req(fetch_Req), .fetch_Lag(fetch_Lag),
        .rd_En(rd_En), .rd_Addr(rd_Addr), .data_Valid(data_Valid),
        .data_In(data_In), .sample_Out(sample_Out), .sample_Valid(sample_Valid),
        .busy(busy), .rd_Err(rd_Err)
    );

    always #5 sClk = ~sClk;

    // Write n samples on consecutive cycles.
    task automatic add_samples(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sClk);
            wp = wp + 8'd1;
            mem[wp] = 16'($urandom);
            wr_Ptr = wp;
            new_Sample = 1'b1;
            if (model_cnt < 256) model_cnt++;
        end
        @(negedge sClk);
        new_Sample = 1'b0;
    endtask

    task automatic do_start();
        @(negedge sClk);
        start = 1'b1;
        @(negedge sClk);
        start = 1'b0;
        model_cnt = 0;
        model_err = 0;
    endtask

    // Issue one fetch and act as the memory; dly = rd_En cycles before data_Valid (-1: never).
    // Observations are indexed by negedges after the acceptance edge (first = 1).
    task automatic run_fetch(input logic [7:0] k, input int dly, input bit co_sample,
                             input int hold_req, input int start_at,
                             output logic [7:0] o_addr, output logic [15:0] o_data,
                             output int o_vcnt, output int o_rden, output int o_vidx,
                             output bit o_moved, output bit o_busy1);
        o_addr = '0; o_data = '0; o_vcnt = 0; o_rden = 0; o_vidx = -1;
        o_moved = 0; o_busy1 = 0;
        @(negedge sClk);
        fetch_Req = 1'b1;
        fetch_Lag = k;
        if (co_sample) begin
            wp = wp + 8'd1;
            mem[wp] = 16'($urandom);
            wr_Ptr = wp;
            new_Sample = 1'b1;
        end
        @(negedge sClk);
        new_Sample = 1'b0;
        if (co_sample && model_cnt < 256) model_cnt++;
        for (int i = 1; i <= 14; i++) begin
            if (i == 1) o_busy1 = busy;
            if (i > hold_req) fetch_Req = 1'b0;
            else fetch_Lag = k ^ 8'h55;
            start = (start_at == i);
            if (sample_Valid) begin
                o_vcnt++;
                o_data = sample_Out;
                if (o_vidx < 0) o_vidx = i;
            end
            if (rd_En) begin
                if (o_rden == 0) o_addr = rd_Addr;
                else if (rd_Addr !== o_addr) o_moved = 1;
                o_rden++;
            end
            data_Valid = 1'b0;
            data_In = 16'($urandom);
            if (rd_En && dly >= 0 && o_rden == dly + 1) begin
                data_Valid = 1'b1;
                data_In = mem[rd_Addr];
            end
            @(negedge sClk);
        end
        data_Valid = 1'b0;
        fetch_Req = 1'b0;
        start = 1'b0;
        if (start_at > 0) begin
            model_cnt = 0;
            model_err = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; new_Sample = 0; wr_Ptr = '0; fetch_Req = 0;
        fetch_Lag = '0; data_Valid = 0; data_In = '0;
        wp = 8'hFF; model_cnt = 0; model_err = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        repeat (3) @(negedge sClk);
        total += 6;
        if (rd_En !== 1'b0) begin bad++; $display("FAIL reset_rd_En got=%b exp=0", rd_En); end
        if (rd_Addr !== 8'h00) begin bad++; $display("FAIL reset_rd_Addr got=%h exp=00", rd_Addr); end
        if (sample_Out !== 16'h0) begin bad++; $display("FAIL reset_sample_Out got=%h exp=0", sample_Out); end
        if (sample_Valid !== 1'b0) begin bad++; $display("FAIL reset_sample_Valid got=%b exp=0", sample_Valid); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (rd_Err !== 1'b0) begin bad++; $display("FAIL reset_rd_Err got=%b exp=0", rd_Err); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] a; logic [15:0] d; int vc, rc, vi; bit mv, b1;
        add_samples(10);
        mem[6] = 16'h1234;
        run_fetch(8'd3, 1, 0, 0, 0, a, d, vc, rc, vi, mv, b1);
        total += 6;
        if (a !== 8'd6) begin bad++; $display("FAIL basic_addr got=%h exp=06", a); end
        if (d !== 16'h1234) begin bad++; $display("FAIL basic_data got=%h exp=1234", d); end
        if (vc != 1) begin bad++; $display("FAIL basic_vcnt got=%0d exp=1", vc); end
        if (rc != 2) begin bad++; $display("FAIL basic_rden_cycles got=%0d exp=2", rc); end
        if (vi != 3) begin bad++; $display("FAIL basic_valid_idx got=%0d exp=3", vi); end
        if (b1 !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", b1); end
    endtask

    task automatic test_skip();
        logic [7:0] a; logic [15:0] d; int vc, rc, vi; bit mv, b1;
        do_start();
        add_samples(5);
        run_fetch(8'd5, 0, 0, 0, 0, a, d, vc, rc, vi, mv, b1);
        total += 4;
        if (rc != 0) begin bad++; $display("FAIL skip_rden got=%0d exp=0", rc); end
        if (d !== 16'h0) begin bad++; $display("FAIL skip_data got=%h exp=0", d); end
        if (vc != 1) begin bad++; $display("FAIL skip_vcnt got=%0d exp=1", vc); end
        if (vi != 1) begin bad++; $display("FAIL skip_valid_idx got=%0d exp=1", vi); end
    endtask

    task automatic test_wrap();
        logic [7:0] a; logic [15:0] d; int vc, rc, vi; bit mv, b1;
        add_samples(256);
        while (wp != 8'd2) add_samples(1);
        run_fetch(8'd10, 0, 0, 0, 0, a, d, vc, rc, vi, mv, b1);
        total += 3;
        if (a !== 8'hF8) begin bad++; $display("FAIL wrap_addr got=%h exp=f8", a); end
        if (d !== mem[8'hF8]) begin bad++; $display("FAIL wrap_data got=%h exp=%h", d, mem[8'hF8]); end
        if (vc != 1) begin bad++; $display("FAIL wrap_vcnt got=%0d exp=1", vc); end
        // Largest lag still wraps: 255 back from wr_Ptr.
        run_fetch(8'd255, 0, 0, 0, 0, a, d, vc, rc, vi, mv, b1);
        total += 1;
        if (a !== 8'(wp + 8'd1)) begin bad++; $display("FAIL wrap255_addr got=%h exp=%h", a, 8'(wp + 8'd1)); end
    endtask

    task automatic test_timeout();
        logic [7:0] a; logic [15:0] d; int vc, rc, vi; bit mv, b1;
        run_fetch(8'd1, -1, 0, 0, 0, a, d, vc, rc, vi, mv, b1);
        model_err = 1;
        total += 5;
        if (rc != TO) begin bad++; $display("FAIL timeout_rden got=%0d exp=%0d", rc, TO); end
        if (vc != 0) begin bad++; $display("FAIL timeout_vcnt got=%0d exp=0", vc); end
        if (rd_Err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b exp=1", rd_Err); end
        if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy got=%b exp=0", busy); end
        if (mv) begin bad++; $display("FAIL timeout_addr_stable got=moved exp=stable"); end
        do_start();
        total += 1;
        if (rd_Err !== 1'b0) begin bad++; $display("FAIL start_clears_err got=%b exp=0", rd_Err); end
    endtask

    task automatic test_busy_abort();
        logic [7:0] a; logic [15:0] d; int vc, rc, vi; bit mv, b1;
        add_samples(8);
        run_fetch(8'd2, 3, 0, 3, 0, a, d, vc, rc, vi, mv, b1);
        total += 5;
        if (a !== 8'(wp - 8'd2)) begin bad++; $display("FAIL busy_addr got=%h exp=%h", a, 8'(wp - 8'd2)); end
        if (mv) begin bad++; $display("FAIL busy_addr_stable got=moved exp=stable"); end
        if (rc != 4) begin bad++; $display("FAIL busy_rden got=%0d exp=4", rc); end
        if (vc != 1) begin bad++; $display("FAIL busy_vcnt got=%0d exp=1", vc); end
        if (d !== mem[8'(wp - 8'd2)]) begin bad++; $display("FAIL busy_data got=%h exp=%h", d, mem[8'(wp - 8'd2)]); end
        run_fetch(8'd2, -1, 0, 0, 2, a, d, vc, rc, vi, mv, b1);
        total += 4;
        if (rc != 2) begin bad++; $display("FAIL abort_rden got=%0d exp=2", rc); end
        if (vc != 0) begin bad++; $display("FAIL abort_vcnt got=%0d exp=0", vc); end
        if (busy !== 1'b0 || rd_En !== 1'b0) begin bad++; $display("FAIL abort_idle got busy=%b rd_En=%b exp=0/0", busy, rd_En); end
        if (rd_Err !== 1'b0) begin bad++; $display("FAIL abort_err got=%b exp=0", rd_Err); end
    endtask

    task automatic test_random();
        logic [7:0] a; logic [15:0] d; int vc, rc, vi; bit mv, b1;
        logic [7:0] k, ea; int dly; bit co, skip;
        for (int it = 0; it < 40; it++) begin
            add_samples($urandom_range(0, 12));
            k   = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, model_cnt + 2));
            dly = $urandom_range(0, 5);
            co  = ($urandom_range(0, 3) == 0);
            skip = (int'(k) >= model_cnt);
            ea  = (co ? 8'(wp + 8'd1) : wp) - k;
            run_fetch(k, dly, co, 0, 0, a, d, vc, rc, vi, mv, b1);
            total += 3;
            if (skip) begin
                if (rc != 0 || vc != 1 || d !== 16'h0) begin
                    bad++; $display("FAIL rand_skip it=%0d got rden=%0d vcnt=%0d data=%h exp 0/1/0000", it, rc, vc, d);
                end
            end else if (dly >= TO) begin
                model_err = 1;
                if (rc != TO || vc != 0) begin
                    bad++; $display("FAIL rand_timeout it=%0d got rden=%0d vcnt=%0d exp %0d/0", it, rc, vc, TO);
                end
            end else begin
                if (a !== ea || d !== mem[ea] || vc != 1 || rc != dly + 1 || vi != dly + 2 || mv) begin
                    bad++; $display("FAIL rand_fetch it=%0d got addr=%h data=%h vcnt=%0d rden=%0d idx=%0d exp addr=%h data=%h 1/%0d/%0d",
                                    it, a, d, vc, rc, vi, ea, mem[ea], dly + 1, dly + 2);
                end
            end
            if (rd_Err !== model_err) begin bad++; $display("FAIL rand_err it=%0d got=%b exp=%b", it, rd_Err, model_err); end
            if (busy !== 1'b0) begin bad++; $display("FAIL rand_busy_end it=%0d got=%b exp=0", it, busy); end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] a; logic [15:0] d; int vc, rc, vi; bit mv, b1;
        add_samples(3);
        @(negedge sClk);
        fetch_Req = 1'b1; fetch_Lag = 8'd1;
        @(negedge sClk);
        fetch_Req = 1'b0;
        @(negedge sClk);
        total += 1;
        if (busy !== 1'b1 || rd_En !== 1'b1) begin bad++; $display("FAIL areset_pre got busy=%b rd_En=%b exp=1/1", busy, rd_En); end
        #2 reset = 1'b1;
        #1;
        total += 1;
        if ({rd_En, rd_Addr, sample_Out, sample_Valid, busy, rd_Err} !== 28'h0) begin
            bad++; $display("FAIL areset_outputs got rd_En=%b addr=%h out=%h v=%b busy=%b err=%b exp all 0",
                            rd_En, rd_Addr, sample_Out, sample_Valid, busy, rd_Err);
        end
        @(negedge sClk);
        reset = 1'b0;
        model_cnt = 0; model_err = 0;
        add_samples(4);
        run_fetch(8'd1, 0, 0, 0, 0, a, d, vc, rc, vi, mv, b1);
        total += 1;
        if (vc != 1 || d !== mem[8'(wp - 8'd1)]) begin
            bad++; $display("FAIL areset_resume got vcnt=%0d data=%h exp 1/%h", vc, d, mem[8'(wp - 8'd1)]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skip();
        test_wrap();
        test_timeout();
        test_busy_abort();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_reader.md
INPUT_READER -- requirements
Module: input_reader

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning input-memory depth (circular buffer entries).
REQ-002 SHALL have parameter TIMEOUT, default 4, meaning max sClk cycles waited for data_Valid after rd_En.
REQ-003 SHALL have port sClk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  synchronous clear of sample history and FSM (new stream).
REQ-006 SHALL have port new_Sample  input  1  pulse: one sample written to input memory this cycle.
REQ-007 SHALL have port wr_Ptr  input  8  address of most recently written sample x[n].
REQ-008 SHALL have port fetch_Req  input  1  request for x[n-k]; accepted only when busy=0.
REQ-009 SHALL have port fetch_Lag  input  8  lag k, captured with an accepted fetch_Req.
REQ-010 SHALL have port rd_En  output  1  read strobe to input memory.
REQ-011 SHALL have port rd_Addr  output  8  read address to input memory.
REQ-012 SHALL have port data_Valid  input  1  memory read-data qualifier.
REQ-013 SHALL have port data_In  input  16  memory read data.
REQ-014 SHALL have port sample_Out  output  16  fetched sample x[n-k].
REQ-015 SHALL have port sample_Valid  output  1  one-cycle pulse qualifying sample_Out.
REQ-016 SHALL have port busy  output  1  high from fetch acceptance until sample_Valid or error.
REQ-017 SHALL have port rd_Err  output  1  sticky flag: data_Valid timeout occurred.

Function
REQ-018 SHALL keep 9-bit saturating sample_Cnt: +1 on new_Sample, saturates at MEM_DEPTH, cleared by start.
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-020 SHALL, in IDLE with fetch_Req=1, capture fetch_Lag, assert busy next cycle, compute rd_Addr = (wr_Ptr - k) mod 256 (8-bit wrap).
REQ-021 SHALL, when k >= sample_Cnt at acceptance, skip memory: go to DONE, sample_Out=0, no rd_En pulse.
REQ-022 SHALL otherwise go to ISSUE: assert rd_En=1 with rd_Addr stable one cycle after acceptance, then WAIT.
REQ-023 SHALL hold rd_En and rd_Addr stable throughout WAIT until data_Valid sampled high.
REQ-024 SHALL, on data_Valid=1 in ISSUE or WAIT, register data_In into sample_Out, deassert rd_En next cycle, enter DONE.
REQ-025 SHALL, in DONE, pulse sample_Valid=1 exactly one cycle, clear busy same cycle, return to IDLE.
REQ-026 SHALL hold sample_Out until next sample_Valid; sample_Valid never asserted on consecutive cycles.
REQ-027 SHALL ignore fetch_Req while busy=1 (no queuing).
REQ-028 SHALL count cycles with rd_En high; if TIMEOUT reached without data_Valid, drop rd_En, set rd_Err, clear busy, return IDLE, no sample_Valid.
REQ-029 SHALL clear rd_Err only on reset or start.
REQ-030 SHALL give start priority over fetch_Req and new_Sample in same cycle; start mid-fetch aborts (rd_En=0, busy=0, IDLE, no sample_Valid).
REQ-031 SHALL let new_Sample coincident with fetch acceptance update sample_Cnt after the k >= sample_Cnt comparison (compare uses pre-increment count).
REQ-032 SHALL compute lag arithmetic modulo 256 independent of sample_Cnt saturation (k=255, wr_Ptr=0 -> rd_Addr=1).

Reset
REQ-033 SHALL, on reset=1 asynchronously: FSM=IDLE, rd_En=0, rd_Addr=0, sample_Out=0, sample_Valid=0, busy=0, rd_Err=0, sample_Cnt=0, timeout count=0.
REQ-034 SHALL resume normal operation on the first sClk edge after reset deasserts.

Verification
REQ-035 SHALL verify: 10 new_Sample pulses, wr_Ptr=9, fetch k=3, data_Valid 1 cycle after rd_En with data 0x1234 -> rd_Addr=6, sample_Out=0x1234, single sample_Valid pulse.
REQ-036 SHALL verify: sample_Cnt=5, fetch k=5 -> no rd_En, sample_Out=0, sample_Valid one cycle after acceptance.
REQ-037 SHALL verify: sample_Cnt saturated, wr_Ptr=2, k=10 -> rd_Addr=0xF8 (wrap), correct data returned.
REQ-038 SHALL verify: data_Valid withheld -> rd_En high 4 cycles then low, rd_Err=1, busy=0, no sample_Valid; start clears rd_Err.
REQ-039 SHALL verify: fetch_Req during busy ignored; start asserted in WAIT aborts cleanly.
REQ-040 SHALL verify: reset asserted mid-WAIT asynchronously zeroes all outputs before next sClk edge.
